bcd_alu_sequencer: RTL and testbench
====================================

// Module: bcd_alu_sequencer
// PURPOSE
//  Multi-cycle controller that sequences one shared single-digit BCD adder over signed-magnitude
//  operands. Computes SUM, SUB and MUL for the calculator FSM. Digit-serial, LSD first.
//  Start/busy/done handshake. Result is held until the next accepted start.
// PARAMETERS
//  DIGIT_NUM  8  BCD digits per operand/result (N below)
// PORTS
//  clock        in   1     system clock, all logic on rising edge
//  reset        in   1     synchronous, active-high
//  start        in   1     request; accepted only in IDLE
//  op           in   3     000 SUM, 001 SUB, 010 MUL, 011 DIV, 100 EXP
//  a            in   4N    operand 0 magnitude, BCD
//  a_sign       in   1     operand 0 sign, 1 = negative
//  b            in   4N    operand 1 magnitude, BCD
//  b_sign       in   1     operand 1 sign
//  busy         out  1     high from the cycle after accept through the last compute cycle
//  done         out  1     one-cycle pulse; result/flags valid from this cycle
//  result       out  4N    result magnitude, BCD, truncated to N digits
//  result_sign  out  1     result sign; forced 0 when result == 0
//  overflow     out  1     nonzero digit lost (carry out of the MSD or MUL shift)
//  error        out  1     unsupported op or non-BCD input digit (>9)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE. Reset mid-operation aborts: IDLE next cycle, no done.
//  Accept: start=1 in IDLE captures op/a/a_sign/b/b_sign; inputs may change afterwards.
//  start while not IDLE is ignored. DONE always returns to IDLE; a new start is accepted from IDLE.
//  States: IDLE -> PREP -> {ADD [-> COMPL] | MSHIFT/MADD loop} -> DONE -> IDLE.
//  PREP (1 cycle): clear flags and accumulator.
//   Any digit > 9 or op not in {SUM, SUB, MUL}: error=1, result=0, go to DONE.
//  SUM/SUB: bs = b_sign ^ (op==SUB); eff_sub = a_sign ^ bs.
//   ADD: N cycles, one digit per cycle, carry register between digits.
//   eff_sub=0: add |a|+|b|, carry-in 0; sign = a_sign; final carry -> overflow.
//   eff_sub=1: add |a| + 9's complement(|b|), carry-in 1.
//    Final carry = 1: result as computed, sign = a_sign.
//    Final carry = 0: COMPL pass, N cycles, result = 10's complement of itself; sign = ~a_sign.
//  MUL: acc = 0. For each a digit, MSD to LSD:
//   MSHIFT, 1 cycle: acc <<= 4; a nonzero top digit shifted out sets overflow.
//   MADD, d times (d = that a digit): N-cycle digit-serial pass, acc += |b|; carry out sets overflow.
//   sign = a_sign ^ b_sign.
//  Overflow is sticky for the operation. result keeps the low N digits.
//  Latency, counted from the accept edge to the cycle with done=1:
//   SUM/SUB: N+2, or 2N+2 with COMPL.  MUL: 2 + N + N*sum(a digits).  error: 2.
//  done is high exactly one cycle, with busy=0. Outputs hold until the next accept.
//  Zero result always reports result_sign=0 (includes -0 from COMPL and MUL).
// TESTING (N=8; cycles counted from the accept edge)
//  SUM 00000123 + 00000877 -> 00001000, sign 0, ovf 0; done at cycle 10.
//  SUB 00000005 - 00000012 -> 00000007, sign 1 (COMPL); done at cycle 18.
//  SUM -00000005 + 00000005 -> 00000000, sign 0.
//  SUM 99999999 + 00000001 -> result 00000000, overflow 1; done at cycle 10.
//  MUL -00000012 * 00000034 -> 00000408, sign 1; done at cycle 34.
//   A second start pulsed during busy is ignored (exactly one done).
//  op=DIV -> error 1, result 0, done at cycle 2.
//   a=0000000A with op=SUM -> error 1.
//  Reset asserted at cycle 5 of a MUL -> busy 0 next cycle, no done.
//   A new SUM then completes normally.

Source files
------------

// File: rtl/bcd_alu_sequencer.sv
// Digit-serial signed-magnitude BCD ALU (SUM, SUB, MUL) that time-shares one
// single-digit BCD adder, least significant digit first, behind a start/busy/done handshake.
module bcd_alu_sequencer #(
  parameter int DIGIT_NUM = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [4*DIGIT_NUM-1:0] a,
  input  logic                   a_sign,
  input  logic [4*DIGIT_NUM-1:0] b,
  input  logic                   b_sign,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGIT_NUM-1:0] result,
  output logic                   result_sign,
  output logic                   overflow,
  output logic                   error
);

  localparam int W  = 4 * DIGIT_NUM;
  localparam int CW = $clog2(DIGIT_NUM + 1);
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  typedef enum logic [2:0] {IDLE, PREP, ADD, COMPL, MSHIFT, MADD, DONE} state_t;

  state_t         state, next_state;
  logic [2:0]     op_r;
  logic [W-1:0]   a_r, b_r, acc;
  logic           a_sign_r, b_sign_r, sign_r, carry, ovf_r, err_r;
  logic [CW-1:0]  cnt, mdig;
  logic [3:0]     mrep;

  logic [3:0]     x, y, digit;
  logic [4:0]     sum5;
  logic           cout, eff_sub, last_digit, bad_input;
  logic [3:0]     top_digit;

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGIT_NUM; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  assign eff_sub    = a_sign_r ^ b_sign_r ^ (op_r == OP_SUB);
  assign last_digit = (cnt == CW'(DIGIT_NUM - 1));
  assign bad_input  = bad_bcd(a_r) | bad_bcd(b_r) | (op_r > OP_MUL);
  assign top_digit  = a_r[W-1 -: 4];

  // Shared digit adder: operand selection depends on which pass is running.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    x = acc[3:0];
    y = b_r[3:0];
    unique case (state)
      ADD:     begin x = a_r[3:0]; y = eff_sub ? 4'd9 - b_r[3:0] : b_r[3:0]; end
      COMPL:   begin x = 4'd9 - acc[3:0]; y = 4'd0; end
      default: ;
    endcase
    sum5 = 5'(x) + 5'(y) + 5'(carry);
    cout = (sum5 > 5'd9);
    digit = cout ? 4'(sum5 - 5'd10) : sum5[3:0];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start) next_state = PREP;
      PREP:   if (bad_input)            next_state = DONE;
              else if (op_r == OP_MUL)  next_state = MSHIFT;
              else                      next_state = ADD;
      ADD:    if (last_digit) next_state = (eff_sub && !cout) ? COMPL : DONE;
      COMPL:  if (last_digit) next_state = DONE;
      MSHIFT: if (top_digit != 4'd0)             next_state = MADD;
              else if (mdig == CW'(DIGIT_NUM-1)) next_state = DONE;
      MADD:   if (last_digit) begin
                if (mrep > 4'd1)                 next_state = MADD;
                else if (mdig == CW'(DIGIT_NUM)) next_state = DONE;
                else                             next_state = MSHIFT;
              end
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: results shift in at the MSD while operands rotate under the adder.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      op_r <= '0; a_r <= '0; b_r <= '0; acc <= '0;
      a_sign_r <= 1'b0; b_sign_r <= 1'b0; sign_r <= 1'b0;
      carry <= 1'b0; ovf_r <= 1'b0; err_r <= 1'b0;
      cnt <= '0; mdig <= '0; mrep <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_r <= op; a_r <= a; b_r <= b; a_sign_r <= a_sign; b_sign_r <= b_sign;
        end
        PREP: begin
          acc <= '0; ovf_r <= 1'b0; err_r <= bad_input;
          cnt <= '0; mdig <= '0; mrep <= '0;
          carry  <= (op_r != OP_MUL) && eff_sub;
          sign_r <= bad_input ? 1'b0 : (op_r == OP_MUL) ? (a_sign_r ^ b_sign_r) : a_sign_r;
        end
        ADD: begin
          acc   <= {digit, acc[W-1:4]};
          a_r   <= {a_r[3:0], a_r[W-1:4]};
          b_r   <= {b_r[3:0], b_r[W-1:4]};
          carry <= cout;
          cnt   <= last_digit ? '0 : cnt + 1'b1;
          if (last_digit) begin
            if (!eff_sub) ovf_r <= cout;
            else if (!cout) begin
              carry  <= 1'b1;
              sign_r <= ~a_sign_r;
            end
          end
        end
        COMPL: begin
          acc   <= {digit, acc[W-1:4]};
          carry <= cout;
          cnt   <= last_digit ? '0 : cnt + 1'b1;
        end
        MSHIFT: begin
          acc   <= {acc[W-5:0], 4'd0};
          a_r   <= {a_r[W-5:0], 4'd0};
          mrep  <= top_digit;
          mdig  <= mdig + 1'b1;
          carry <= 1'b0;
          if (acc[W-1 -: 4] != 4'd0) ovf_r <= 1'b1;
        end
        MADD: begin
          acc   <= {digit, acc[W-1:4]};
          b_r   <= {b_r[3:0], b_r[W-1:4]};
          carry <= cout;
          cnt   <= last_digit ? '0 : cnt + 1'b1;
          if (last_digit) begin
            carry <= 1'b0;
            mrep  <= mrep - 4'd1;
            if (cout) ovf_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign result      = acc;
  assign result_sign = sign_r & (acc != '0);
  assign overflow    = ovf_r;
  assign error       = err_r;

endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Self-checking bench for bcd_alu_sequencer: table of operations with expected
// results and latencies, scoreboard queue, plus mid-operation start and reset sequences.
module tb_bcd_alu_sequencer;

  localparam int N   = 8;
  localparam int WIN = 60;

  logic          clock = 1'b0;
  logic          reset, start, a_sign, b_sign;
  logic [2:0]    op;
  logic [4*N-1:0] a, b, result;
  logic          busy, done, result_sign, overflow, error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic        as;
    logic [31:0] b;
    logic        bs;
    logic [31:0] res;
    logic        rs;
    logic        ov;
    logic        er;
    int          lat;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[16];

  bcd_alu_sequencer #(.DIGIT_NUM(N)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a(a), .a_sign(a_sign), .b(b), .b_sign(b_sign),
    .busy(busy), .done(done), .result(result), .result_sign(result_sign),
    .overflow(overflow), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one operation and watch a fixed window; optionally pulse a second
  // start at glitch_at or assert reset at reset_at (cycles after the accept edge).
  task automatic run_vec(input vec_t v, input string tag, input int glitch_at, input int reset_at);
    int ndone, done_cyc;
    vec_t e;
    ndone = 0;
    done_cyc = -1;
    op = v.op; a = v.a; a_sign = v.as; b = v.b; b_sign = v.bs;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (reset_at == 0) sb.push_back(v);
    op = 3'($urandom); a = $urandom; b = $urandom;
    a_sign = 1'($urandom); b_sign = 1'($urandom);
    check({tag, "_busy_c1"}, {63'd0, busy}, 64'd1);
    for (int cyc = 1; cyc <= WIN; cyc++) begin
      if (cyc > 1) begin
        @(posedge clock); #1;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_cyc = cyc;
          check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
          if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check({tag, "_result"}, {32'd0, result}, {32'd0, e.res});
            check({tag, "_sign"}, {63'd0, result_sign}, {63'd0, e.rs});
            check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, e.ov});
            check({tag, "_error"}, {63'd0, error}, {63'd0, e.er});
          end
        end
      end
      if (reset_at > 0 && cyc == reset_at + 1) begin
        check({tag, "_busy_after_reset"}, {63'd0, busy}, 64'd0);
        check({tag, "_result_after_reset"}, {32'd0, result}, 64'd0);
        reset = 1'b0;
      end
      if (reset_at > 0 && cyc == reset_at) reset = 1'b1;
      start = (cyc == glitch_at);
    end
    start = 1'b0;
    if (reset_at == 0) begin
      check({tag, "_done_count"}, 64'(ndone), 64'd1);
      check({tag, "_latency"}, 64'(done_cyc), 64'(v.lat));
    end else begin
      check({tag, "_no_done"}, 64'(ndone), 64'd0);
    end
  endtask

  initial begin
    //          op    a             as    b             bs    result        rs    ov    er    lat
    vecs[0]  = '{3'd0, 32'h00000123, 1'b0, 32'h00000877, 1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0, 10};
    vecs[1]  = '{3'd1, 32'h00000005, 1'b0, 32'h00000012, 1'b0, 32'h00000007, 1'b1, 1'b0, 1'b0, 18};
    vecs[2]  = '{3'd0, 32'h00000005, 1'b1, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 10};
    vecs[3]  = '{3'd0, 32'h99999999, 1'b0, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 10};
    vecs[4]  = '{3'd2, 32'h00000012, 1'b1, 32'h00000034, 1'b0, 32'h00000408, 1'b1, 1'b0, 1'b0, 34};
    vecs[5]  = '{3'd3, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[6]  = '{3'd0, 32'h0000000A, 1'b1, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[7]  = '{3'd1, 32'h00000050, 1'b0, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 10};
    vecs[8]  = '{3'd0, 32'h00000007, 1'b1, 32'h00000003, 1'b1, 32'h00000010, 1'b1, 1'b0, 1'b0, 10};
    vecs[9]  = '{3'd2, 32'h00000000, 1'b1, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 10};
    vecs[10] = '{3'd2, 32'h00000003, 1'b0, 32'h99999999, 1'b0, 32'h99999997, 1'b0, 1'b1, 1'b0, 34};
    vecs[11] = '{3'd2, 32'h10000000, 1'b0, 32'h00000020, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 18};
    vecs[12] = '{3'd4, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[13] = '{3'd2, 32'h00000002, 1'b0, 32'h000000F0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[14] = '{3'd1, 32'h00000012, 1'b1, 32'h00000005, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 10};
    vecs[15] = '{3'd1, 32'h00000100, 1'b0, 32'h00000100, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 10};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_sign", {63'd0, result_sign}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    check("reset_error", {63'd0, error}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 16; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i), (i == 4) ? 5 : 0, 0);

    // Reset during a MUL aborts it; the following SUM must complete normally.
    run_vec(vecs[4], "mul_reset", 0, 5);
    run_vec(vecs[0], "sum_after_reset", 0, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
